bp_cce_mem_stream_mux: RTL
==========================

Name: bp_cce_mem_stream_mux

Overview:
- Merges the CCE-MEM BedRock Stream command channels of num_cce_p CCE instances onto one memory port.
- Routes memory responses back to the issuing CCE using a source-index field carried in the message header.
- Sits between a multi-slice CCE array (ucode or FSM CCEs) and the shared memory/L2 interface.
- Arbitration is round-robin and burst-locked, so a multi-beat command stream is never interleaved with another CCE's stream.

Parameters:
- num_cce_p, 4: number of CCE-side channels; must be ≥2 and a power of two.
- header_width_p, 128: width of the BedRock mem header in bits.
- data_width_p, 64: width of a BedRock data beat in bits.
- src_lsb_p, 0: LSB position of the source-index field within the header.
- src_width_lp, log2(num_cce_p): width of the source-index field (derived).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- cce_cmd_header_i  in  num_cce_p*header_width_p  per-channel command headers.
- cce_cmd_header_v_i / cce_cmd_header_ready_and_o  in/out  num_cce_p  header handshake.
- cce_cmd_has_data_i  in  num_cce_p  header is followed by data beats.
- cce_cmd_data_i  in  num_cce_p*data_width_p  per-channel command data.
- cce_cmd_data_v_i / cce_cmd_data_ready_and_o  in/out  num_cce_p  data handshake.
- cce_cmd_last_i  in  num_cce_p  final data beat.
- mem_cmd_header_o, _v_o / mem_cmd_header_ready_and_i  out/out/in  header_width_p/1/1  merged command header.
- mem_cmd_has_data_o  out  1  merged command has data.
- mem_cmd_data_o, _v_o / mem_cmd_data_ready_and_i  out/out/in  data_width_p/1/1  merged command data.
- mem_cmd_last_o  out  1  merged last beat.
- mem_resp_header_i, _v_i / mem_resp_header_ready_and_o  in/in/out  header_width_p/1/1  response header.
- mem_resp_has_data_i  in  1  response has data.
- mem_resp_data_i, _v_i / mem_resp_data_ready_and_o  in/in/out  data_width_p/1/1  response data.
- mem_resp_last_i  in  1  response last beat.
- cce_resp_header_o, _v_o / cce_resp_header_ready_and_i, cce_resp_has_data_o, cce_resp_data_o, _v_o / cce_resp_data_ready_and_i, cce_resp_last_o  out/in  per-channel  demuxed responses; widths are num_cce_p times the mem-side widths.

Behaviour:
- Handshake: all channels are ready&valid. A transfer occurs when valid & ready_and are both high. Valid never depends on ready within this block.
- Reset (reset_n_i=0 at a clock edge):
  - both FSMs go to IDLE; rr_ptr=0; all valid and ready outputs are 0.
  - Reset mid-burst abandons the burst; no partial beats are emitted after reset.
- Command FSM states: IDLE, HOLD, DATA.
- IDLE:
  - grant = first channel with header_v set, searching from rr_ptr upward with wrap-around.
  - mem_cmd_header_v_o = 1 if any channel is valid. The header is the granted channel's header with bits [src_lsb_p +: src_width_lp] overwritten with the grant index.
  - has_data passes through from the granted channel.
  - Only the granted channel's header_ready_and_o mirrors mem_cmd_header_ready_and_i; all others are 0.
- IDLE transitions:
  - Header handshake with has_data=1: go to DATA; rr_ptr = grant+1 mod num_cce_p.
  - Header handshake with has_data=0: stay in IDLE; rr_ptr advances the same way.
  - Valid but no handshake: latch grant and go to HOLD, so the output is never retracted or switched.
- HOLD: grant is fixed to the latched channel. Same handshake and transitions as IDLE.
- DATA:
  - All cce header readies are 0; mem_cmd_header_v_o=0.
  - data, data_v and last pass through from the locked channel; that channel's data_ready_and_o = mem_cmd_data_ready_and_i.
  - A data handshake with last=1 returns to IDLE. A new header is accepted no earlier than the next cycle (one-cycle bubble).
- Data outside DATA: mem_cmd_data_v_o=0 and all cce data readies are 0.
- Response FSM states: RIDLE, RDATA.
- RIDLE:
  - dest = mem_resp_header_i[src_lsb_p +: src_width_lp].
  - cce_resp_header_v_o[dest] = mem_resp_header_v_i; header is forwarded unmodified.
  - mem_resp_header_ready_and_o = cce_resp_header_ready_and_i[dest].
  - Header handshake with has_data=1: register dest and go to RDATA.
- RDATA:
  - Data beats route to the registered dest; mem_resp_header_ready_and_o=0.
  - last handshake returns to RIDLE.
- Data outside RDATA: mem_resp_data_ready_and_o=0.
- Simultaneous events: command and response paths are fully independent, and a command and a response may both transfer in the same cycle.
- Latency: combinational pass-through with zero cycles added; arbitration state updates only on handshakes.

Test Plan:
- Reset: hold reset_n_i=0 for 3 cycles with all inputs valid → all valid and ready outputs are 0; after release the first grant goes to channel 0.
- Fairness: channels 0–3 issue no-data headers continuously with mem ready=1 → grants go 0,1,2,3,0…, one per cycle, each with src field = index.
- Burst lock: channel 1 sends a header with has_data plus 4 data beats while channel 2 holds a valid header → channel 2 header_ready stays 0 until channel 1's last handshake, then channel 2 is granted after one bubble cycle.
- Backpressure hold: channel 3 valid, mem_cmd_header_ready_and_i=0 for 5 cycles, channel 0 raises valid in cycle 2 → output stays channel 3 until handshake; rr_ptr becomes 0.
- Response routing: response header with src=2 and has_data, 2 beats, with cce_resp_data_ready_and_i[2] toggling → only channel 2 sees valid; beats arrive in order; other channels stay 0.
- Concurrency and reset mid-burst: command burst and response burst run simultaneously → both complete independently; asserting reset during beat 2 → all outputs 0 next cycle and rr_ptr=0.

Source files
------------

// File: rtl/bp_cce_mem_stream_mux.sv
// Merges the CCE-to-memory BedRock Stream command channels of several CCEs onto one memory port.
// Memory responses are steered back to the issuing CCE by the source-index field in the header.
module bp_cce_mem_stream_mux #(
    parameter int num_cce_p      = 4,
    parameter int header_width_p = 128,
    parameter int data_width_p   = 64,
    parameter int src_lsb_p      = 0
) (
    input  logic                                  clk_i,
    input  logic                                  reset_n_i,

    input  logic [num_cce_p*header_width_p-1:0]   cce_cmd_header_i,
    input  logic [num_cce_p-1:0]                  cce_cmd_header_v_i,
    output logic [num_cce_p-1:0]                  cce_cmd_header_ready_and_o,
    input  logic [num_cce_p-1:0]                  cce_cmd_has_data_i,
    input  logic [num_cce_p*data_width_p-1:0]     cce_cmd_data_i,
    input  logic [num_cce_p-1:0]                  cce_cmd_data_v_i,
    output logic [num_cce_p-1:0]                  cce_cmd_data_ready_and_o,
    input  logic [num_cce_p-1:0]                  cce_cmd_last_i,

    output logic [header_width_p-1:0]             mem_cmd_header_o,
    output logic                                  mem_cmd_header_v_o,
    input  logic                                  mem_cmd_header_ready_and_i,
    output logic                                  mem_cmd_has_data_o,
    output logic [data_width_p-1:0]               mem_cmd_data_o,
    output logic                                  mem_cmd_data_v_o,
    input  logic                                  mem_cmd_data_ready_and_i,
    output logic                                  mem_cmd_last_o,

    input  logic [header_width_p-1:0]             mem_resp_header_i,
    input  logic                                  mem_resp_header_v_i,
    output logic                                  mem_resp_header_ready_and_o,
    input  logic                                  mem_resp_has_data_i,
    input  logic [data_width_p-1:0]               mem_resp_data_i,
    input  logic                                  mem_resp_data_v_i,
    output logic                                  mem_resp_data_ready_and_o,
    input  logic                                  mem_resp_last_i,

    output logic [num_cce_p*header_width_p-1:0]   cce_resp_header_o,
    output logic [num_cce_p-1:0]                  cce_resp_header_v_o,
    input  logic [num_cce_p-1:0]                  cce_resp_header_ready_and_i,
    output logic [num_cce_p-1:0]                  cce_resp_has_data_o,
    output logic [num_cce_p*data_width_p-1:0]     cce_resp_data_o,
    output logic [num_cce_p-1:0]                  cce_resp_data_v_o,
    input  logic [num_cce_p-1:0]                  cce_resp_data_ready_and_i,
    output logic [num_cce_p-1:0]                  cce_resp_last_o
);

    localparam int src_width_lp = $clog2(num_cce_p);

    typedef enum logic [1:0] {IDLE, HOLD, DATA} cmd_state_e;
    typedef enum logic {RIDLE, RDATA} resp_state_e;

    cmd_state_e                cmd_state_q, cmd_state_n;
    resp_state_e               resp_state_q, resp_state_n;
    logic [src_width_lp-1:0]   rr_ptr_q, rr_ptr_n;
    logic [src_width_lp-1:0]   grant_q, grant_n;
    logic [src_width_lp-1:0]   rr_grant, rr_idx, sel;
    logic                      rr_found;
    logic                      cmd_v;
    logic [src_width_lp-1:0]   dest, rdest_q, rdest_n;

    // Round-robin search starting at rr_ptr; index arithmetic wraps since num_cce_p is a power of two.
    always_comb begin
        rr_grant = rr_ptr_q;
        rr_idx   = '0;
        rr_found = 1'b0;
        for (int i = 0; i < num_cce_p; i++) begin
            rr_idx = rr_ptr_q + src_width_lp'(i);
            if (!rr_found && cce_cmd_header_v_i[rr_idx]) begin
                rr_found = 1'b1;
                rr_grant = rr_idx;
            end
        end
    end

    always_comb begin
        cmd_state_n                = cmd_state_q;
        rr_ptr_n                   = rr_ptr_q;
        grant_n                    = grant_q;
        sel                        = (cmd_state_q == IDLE) ? rr_grant : grant_q;
        cmd_v                      = 1'b0;
        mem_cmd_header_o           = '0;
        mem_cmd_header_v_o         = 1'b0;
        mem_cmd_has_data_o         = 1'b0;
        mem_cmd_data_o             = '0;
        mem_cmd_data_v_o           = 1'b0;
        mem_cmd_last_o             = 1'b0;
        cce_cmd_header_ready_and_o = '0;
        cce_cmd_data_ready_and_o   = '0;

        case (cmd_state_q)
            IDLE, HOLD: begin
                cmd_v = (cmd_state_q == IDLE) ? rr_found : cce_cmd_header_v_i[grant_q];
                mem_cmd_header_v_o = cmd_v;
                mem_cmd_header_o   = cce_cmd_header_i[sel*header_width_p +: header_width_p];
                mem_cmd_header_o[src_lsb_p +: src_width_lp] = sel;
                mem_cmd_has_data_o = cce_cmd_has_data_i[sel];
                if (cmd_v) begin
                    cce_cmd_header_ready_and_o[sel] = mem_cmd_header_ready_and_i;
                end
                // An offered header that is not taken stays pinned to its channel until it is.
                if (cmd_v && mem_cmd_header_ready_and_i) begin
                    rr_ptr_n    = sel + src_width_lp'(1);
                    grant_n     = sel;
                    cmd_state_n = cce_cmd_has_data_i[sel] ? DATA : IDLE;
                end else if (cmd_v) begin
                    grant_n     = sel;
                    cmd_state_n = HOLD;
                end
            end
            DATA: begin
                mem_cmd_data_o   = cce_cmd_data_i[grant_q*data_width_p +: data_width_p];
                mem_cmd_data_v_o = cce_cmd_data_v_i[grant_q];
                mem_cmd_last_o   = cce_cmd_last_i[grant_q];
                cce_cmd_data_ready_and_o[grant_q] = mem_cmd_data_ready_and_i;
                if (cce_cmd_data_v_i[grant_q] && mem_cmd_data_ready_and_i && cce_cmd_last_i[grant_q]) begin
                    cmd_state_n = IDLE;
                end
            end
            default: cmd_state_n = IDLE;
        endcase

        if (!reset_n_i) begin
            mem_cmd_header_v_o         = 1'b0;
            mem_cmd_data_v_o           = 1'b0;
            cce_cmd_header_ready_and_o = '0;
            cce_cmd_data_ready_and_o   = '0;
        end
    end

    // Response payloads are broadcast; only the selected channel's valid is raised.
    always_comb begin
        resp_state_n                = resp_state_q;
        rdest_n                     = rdest_q;
        dest                        = mem_resp_header_i[src_lsb_p +: src_width_lp];
        cce_resp_header_o           = {num_cce_p{mem_resp_header_i}};
        cce_resp_has_data_o         = {num_cce_p{mem_resp_has_data_i}};
        cce_resp_data_o             = {num_cce_p{mem_resp_data_i}};
        cce_resp_last_o             = {num_cce_p{mem_resp_last_i}};
        cce_resp_header_v_o         = '0;
        cce_resp_data_v_o           = '0;
        mem_resp_header_ready_and_o = 1'b0;
        mem_resp_data_ready_and_o   = 1'b0;

        case (resp_state_q)
            RIDLE: begin
                cce_resp_header_v_o[dest]   = mem_resp_header_v_i;
                mem_resp_header_ready_and_o = cce_resp_header_ready_and_i[dest];
                if (mem_resp_header_v_i && cce_resp_header_ready_and_i[dest] && mem_resp_has_data_i) begin
                    rdest_n      = dest;
                    resp_state_n = RDATA;
                end
            end
            RDATA: begin
                cce_resp_data_v_o[rdest_q] = mem_resp_data_v_i;
                mem_resp_data_ready_and_o  = cce_resp_data_ready_and_i[rdest_q];
                if (mem_resp_data_v_i && cce_resp_data_ready_and_i[rdest_q] && mem_resp_last_i) begin
                    resp_state_n = RIDLE;
                end
            end
            default: resp_state_n = RIDLE;
        endcase

        if (!reset_n_i) begin
            cce_resp_header_v_o         = '0;
            cce_resp_data_v_o           = '0;
            mem_resp_header_ready_and_o = 1'b0;
            mem_resp_data_ready_and_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            cmd_state_q  <= IDLE;
            resp_state_q <= RIDLE;
            rr_ptr_q     <= '0;
            grant_q      <= '0;
            rdest_q      <= '0;
        end else begin
            cmd_state_q  <= cmd_state_n;
            resp_state_q <= resp_state_n;
            rr_ptr_q     <= rr_ptr_n;
            grant_q      <= grant_n;
            rdest_q      <= rdest_n;
        end
    end

endmodule
